// File: rtl/dcache_line_adapter.sv
// Miss handler between the 2-way L1 data cache and the unified memory port.
// Writes back a dirty LRU victim word by word, then refills the missed line into the cache.
module dcache_line_adapter #(
    parameter int WORD_SIZE      = 32,
    parameter int ADDR_SIZE      = 32,
    parameter int WORDS_PER_LINE = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 cpu_req,
    input  logic [ADDR_SIZE-1:0] cpu_addr,
    input  logic                 cache_hit,
    input  logic                 cache_dirty,
    input  logic [ADDR_SIZE-1:0] cache_aout,
    input  logic [WORD_SIZE-1:0] cache_rdata,
    output logic [ADDR_SIZE-1:0] cache_addr,
    output logic                 addr_sel,
    output logic                 cache_we,
    output logic [WORD_SIZE-1:0] cache_wdata,
    output logic                 stall,
    output logic                 mem_req,
    output logic                 mem_we,
    output logic [ADDR_SIZE-1:0] mem_addr,
    output logic [WORD_SIZE-1:0] mem_wdata,
    input  logic [WORD_SIZE-1:0] mem_rdata,
    input  logic                 mem_ack
);

    localparam int OFS = $clog2(WORDS_PER_LINE);
    localparam int LW  = ADDR_SIZE - OFS - 2;

    typedef enum logic [1:0] {IDLE, WB, FILL, DONE} state_t;

    state_t          r_state;
    state_t          w_nextState;
    logic [OFS-1:0]  r_cnt;
    logic [OFS-1:0]  w_nextCnt;
    logic [LW-1:0]   r_missLine;
    logic [LW-1:0]   r_victimLine;
    logic            w_miss;
    logic            w_lastWord;
    logic            w_unused;

    assign w_miss     = cpu_req & ~cache_hit;
    assign w_lastWord = (r_cnt == OFS'(WORDS_PER_LINE - 1));
    assign w_unused   = ^{cpu_addr[OFS+1:0], cache_aout[OFS+1:0]};

    // Line addresses are captured once at miss detection; the stall keeps the CPU side frozen.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= IDLE;
            r_cnt        <= '0;
            r_missLine   <= '0;
            r_victimLine <= '0;
        end else begin
            r_state <= w_nextState;
            r_cnt   <= w_nextCnt;
            if (r_state == IDLE && w_miss) begin
                r_missLine   <= cpu_addr[ADDR_SIZE-1:OFS+2];
                r_victimLine <= cache_aout[ADDR_SIZE-1:OFS+2];
            end
        end
    end

    always_comb begin
        w_nextState = r_state;
        w_nextCnt   = r_cnt;
        stall       = 1'b0;
        addr_sel    = 1'b0;
        cache_addr  = '0;
        cache_we    = 1'b0;
        cache_wdata = '0;
        mem_req     = 1'b0;
        mem_we      = 1'b0;
        mem_addr    = '0;
        mem_wdata   = '0;
        case (r_state)
            IDLE: begin
                stall = w_miss;
                if (w_miss) begin
                    w_nextCnt   = '0;
                    w_nextState = cache_dirty ? WB : FILL;
                end
            end
            WB: begin
                stall      = 1'b1;
                addr_sel   = 1'b1;
                cache_addr = {r_missLine, r_cnt, 2'b00};
                mem_req    = 1'b1;
                mem_we     = 1'b1;
                mem_addr   = {r_victimLine, r_cnt, 2'b00};
                mem_wdata  = cache_rdata;
                if (mem_ack) begin
                    w_nextCnt = r_cnt + OFS'(1);
                    if (w_lastWord) w_nextState = FILL;
                end
            end
            FILL: begin
                stall      = 1'b1;
                addr_sel   = 1'b1;
                cache_addr = {r_missLine, r_cnt, 2'b00};
                mem_req    = 1'b1;
                mem_addr   = {r_missLine, r_cnt, 2'b00};
                // The cache latches the fill word on the following negedge.
                cache_we   = mem_ack;
                if (mem_ack) begin
                    cache_wdata = mem_rdata;
                    w_nextCnt   = r_cnt + OFS'(1);
                    if (w_lastWord) w_nextState = DONE;
                end
            end
            DONE: begin
                stall       = 1'b1;
                w_nextState = IDLE;
            end
            default: w_nextState = IDLE;
        endcase
        if (reset) begin
            stall       = 1'b0;
            addr_sel    = 1'b0;
            cache_addr  = '0;
            cache_we    = 1'b0;
            cache_wdata = '0;
            mem_req     = 1'b0;
            mem_we      = 1'b0;
            mem_addr    = '0;
            mem_wdata   = '0;
        end
    end

endmodule

// File: tb/tb_dcache_line_adapter.sv
// Directed bench for dcache_line_adapter: hit, clean/dirty/slow misses, reset abort, back-to-back.
module tb_dcache_line_adapter;

    logic        clk = 1'b0;
    logic        reset;
    logic        cpu_req;
    logic [31:0] cpu_addr;
    logic        cache_hit;
    logic        cache_dirty;
    logic [31:0] cache_aout;
    logic [31:0] cache_rdata;
    logic [31:0] cache_addr;
    logic        addr_sel;
    logic        cache_we;
    logic [31:0] cache_wdata;
    logic        stall;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_ack;

    int checks = 0;
    int errors = 0;
    int stallCycles;

    dcache_line_adapter dut (
        .clk(clk), .reset(reset), .cpu_req(cpu_req), .cpu_addr(cpu_addr),
        .cache_hit(cache_hit), .cache_dirty(cache_dirty), .cache_aout(cache_aout),
        .cache_rdata(cache_rdata), .cache_addr(cache_addr), .addr_sel(addr_sel),
        .cache_we(cache_we), .cache_wdata(cache_wdata), .stall(stall),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h at %0t", tag, actual, expected, $time);
        end
    endtask

    task automatic nextCycle;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] wordAddr(input logic [31:0] base, input int i);
        logic [2:0] idx;
        idx = 3'(i);
        return {base[31:5], idx, 2'b00};
    endfunction

    // One memory word: 'delay' wait cycles followed by one ack cycle.
    task automatic serviceWord(input bit isFill, input logic [31:0] expMem, input logic [31:0] expCache,
                               input logic [31:0] data, input int delay);
        for (int w = 0; w <= delay; w++) begin
            mem_ack = (w == delay);
            if (isFill) mem_rdata = data;
            else cache_rdata = data;
            @(negedge clk);
            if (stall) stallCycles++;
            checkOutput("xfer_stall", stall, 1);
            checkOutput("xfer_mem_req", mem_req, 1);
            checkOutput("xfer_mem_we", mem_we, !isFill);
            checkOutput("xfer_mem_addr", mem_addr, expMem);
            checkOutput("xfer_addr_sel", addr_sel, 1);
            checkOutput("xfer_cache_addr", cache_addr, expCache);
            checkOutput("xfer_cache_we", cache_we, isFill && (w == delay));
            if (isFill && w == delay) checkOutput("fill_wdata", cache_wdata, data);
            if (!isFill) checkOutput("wb_mem_wdata", mem_wdata, data);
            nextCycle();
        end
        mem_ack = 1'b0;
    endtask

    task automatic applyStimulus(input logic [31:0] addr, input bit dirty, input logic [31:0] aout,
                                 input int delay, input int expStall);
        cpu_req = 1'b1; cpu_addr = addr; cache_hit = 1'b0;
        cache_dirty = dirty; cache_aout = aout; mem_ack = 1'b0;
        stallCycles = 0;
        @(negedge clk);
        if (stall) stallCycles++;
        checkOutput("detect_stall", stall, 1);
        checkOutput("detect_mem_req", mem_req, 0);
        checkOutput("detect_addr_sel", addr_sel, 0);
        nextCycle();
        if (dirty)
            for (int i = 0; i < 8; i++)
                serviceWord(1'b0, wordAddr(aout, i), wordAddr(addr, i), 32'hC0 + 32'(i), delay);
        for (int i = 0; i < 8; i++)
            serviceWord(1'b1, wordAddr(addr, i), wordAddr(addr, i), 32'hA0 + 32'(i), delay);
        cache_hit = 1'b1;
        @(negedge clk);
        if (stall) stallCycles++;
        checkOutput("done_stall", stall, 1);
        checkOutput("done_mem_req", mem_req, 0);
        checkOutput("done_addr_sel", addr_sel, 0);
        checkOutput("done_cache_we", cache_we, 0);
        nextCycle();
        @(negedge clk);
        if (stall) stallCycles++;
        checkOutput("idle_stall", stall, 0);
        checkOutput("idle_mem_req", mem_req, 0);
        checkOutput("stall_cycles", 32'(stallCycles), 32'(expStall));
        nextCycle();
    endtask

    initial begin
        reset = 1'b1; cpu_req = 1'b1; cpu_addr = 32'h1044; cache_hit = 1'b0;
        cache_dirty = 1'b1; cache_aout = 32'h2043; cache_rdata = 32'h55;
        mem_rdata = 32'h66; mem_ack = 1'b1;
        nextCycle();
        @(negedge clk);
        checkOutput("rst_stall", stall, 0);
        checkOutput("rst_mem_req", mem_req, 0);
        checkOutput("rst_mem_we", mem_we, 0);
        checkOutput("rst_cache_we", cache_we, 0);
        checkOutput("rst_addr_sel", addr_sel, 0);
        checkOutput("rst_mem_addr", mem_addr, 0);
        checkOutput("rst_cache_addr", cache_addr, 0);
        nextCycle();
        reset = 1'b0; mem_ack = 1'b0; cache_hit = 1'b1; cache_dirty = 1'b0;

        // Hit: no memory traffic for five cycles.
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            checkOutput("hit_stall", stall, 0);
            checkOutput("hit_mem_req", mem_req, 0);
            checkOutput("hit_cache_we", cache_we, 0);
            nextCycle();
        end
        cpu_req = 1'b0;

        applyStimulus(32'h1044, 1'b0, 32'h2043, 0, 10);
        applyStimulus(32'h1044, 1'b1, 32'h2043, 0, 18);
        applyStimulus(32'h1044, 1'b0, 32'h2043, 3, 34);

        // Reset while the fill is at word 3.
        cpu_req = 1'b1; cpu_addr = 32'h1044; cache_hit = 1'b0; cache_dirty = 1'b0;
        nextCycle();
        for (int i = 0; i < 3; i++)
            serviceWord(1'b1, wordAddr(32'h1044, i), wordAddr(32'h1044, i), 32'hA0 + 32'(i), 0);
        @(negedge clk);
        checkOutput("pre_rst_mem_addr", mem_addr, 32'h104C);
        reset = 1'b1; cpu_req = 1'b0;
        @(negedge clk);
        checkOutput("midrst_mem_req", mem_req, 0);
        nextCycle();
        reset = 1'b0; mem_ack = 1'b1; mem_rdata = 32'hEE;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            checkOutput("abort_mem_req", mem_req, 0);
            checkOutput("abort_stall", stall, 0);
            checkOutput("abort_cache_we", cache_we, 0);
            nextCycle();
        end
        mem_ack = 1'b0;

        // Back-to-back misses; the second must start at word 0 of its line.
        applyStimulus(32'h1044, 1'b0, 32'h2043, 0, 10);
        applyStimulus(32'h3010, 1'b0, 32'h2043, 0, 10);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL timeout: got running expected finished");
        $fatal(1, "[TB] timeout");
    end

endmodule
